// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame scanner: pixel layout,
// default line timing and the scanner FSM encoding.
package ws2812_pkg;

    localparam int PIXEL_W = 24;

    // GRB order on the wire: green byte goes out first.
    localparam int G_LSB = 16;
    localparam int R_LSB = 8;
    localparam int B_LSB = 0;

    localparam int DEF_LED_NUM    = 64;
    localparam int DEF_RD_LATENCY = 2;
    localparam int DEF_T0H        = 18;
    localparam int DEF_T1H        = 35;
    localparam int DEF_TBIT       = 63;
    localparam int DEF_TRST       = 14000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_SEND     = 2'd2,
        ST_LATCH    = 2'd3
    } scan_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Single WS2812 bit-period generator: a load starts one TBIT-long period whose
// high time depends on the bit value captured with the load.
module ws2812_bit_tx
    import ws2812_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic load_in,
    input  logic bit_in,
    output logic dout_out,
    output logic bit_end_out
);

    localparam int              PH_W    = cnt_width(TBIT - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(TBIT - 1);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            bit_q, bit_d;
    logic            active_q, active_d;
    logic            dout_q, dout_d;
    logic            bit_end;

    function automatic logic high_at(input logic [PH_W-1:0] ph, input logic b);
        return int'(ph) < (b ? T1H : T0H);
    endfunction

    assign bit_end = active_q && (phase_q == PH_LAST);

    // A load in the last phase of a period starts the next one seamlessly.
    always_comb begin
        phase_d  = phase_q;
        bit_d    = bit_q;
        active_d = active_q;
        dout_d   = dout_q;
        if (load_in) begin
            phase_d  = '0;
            bit_d    = bit_in;
            active_d = 1'b1;
            dout_d   = high_at('0, bit_in);
        end else if (bit_end) begin
            phase_d  = '0;
            active_d = 1'b0;
            dout_d   = 1'b0;
        end else if (active_q) begin
            phase_d = phase_q + 1'b1;
            dout_d  = high_at(phase_d, bit_q);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            phase_q  <= '0;
            bit_q    <= 1'b0;
            active_q <= 1'b0;
            dout_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            active_q <= active_d;
            dout_q   <= dout_d;
        end
    end

    assign dout_out    = dout_q;
    assign bit_end_out = bit_end;

endmodule

// File: rtl/ws2812_frame_scan.sv
// Frame scanner: walks LED indices, prefetches each GRB pixel from the
// framebuffer and streams it out through ws2812_bit_tx, then holds the latch.
module ws2812_frame_scan
    import ws2812_pkg::*;
#(
    parameter int LED_NUM    = DEF_LED_NUM,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int T0H        = DEF_T0H,
    parameter int T1H        = DEF_T1H,
    parameter int TBIT       = DEF_TBIT,
    parameter int TRST       = DEF_TRST,
    localparam int IDX_W     = cnt_width(LED_NUM - 1)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    output logic [IDX_W-1:0]   idx_out,
    input  logic [PIXEL_W-1:0] pixel_in,
    output logic               dout_out,
    output logic               busy_out,
    output logic               done_out
);

    localparam int               LAT_W    = cnt_width(RD_LATENCY);
    localparam int               LCH_W    = cnt_width(TRST);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY);
    localparam logic [LCH_W-1:0] LCH_LAST = LCH_W'(TRST - 1);
    localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(LED_NUM - 1);
    localparam logic [4:0]       BIT_LAST = 5'(PIXEL_W - 1);

    if (!(T0H < T1H && T1H < TBIT)) begin : g_bad_timing
        $error("ws2812_frame_scan: need T0H < T1H < TBIT");
    end
    if (RD_LATENCY < 0 || RD_LATENCY >= PIXEL_W * TBIT) begin : g_bad_latency
        $error("ws2812_frame_scan: need 0 <= RD_LATENCY < 24*TBIT");
    end
    if (LED_NUM < 1 || TRST < 1) begin : g_bad_size
        $error("ws2812_frame_scan: need LED_NUM >= 1 and TRST >= 1");
    end

    scan_state_e        state_q, state_d;
    logic [LAT_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [LAT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic               fetch_busy_q, fetch_busy_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LCH_W-1:0]   latch_cnt_q, latch_cnt_d;
    logic [PIXEL_W-1:0] shift_q, shift_d;
    logic [PIXEL_W-1:0] hold_q, hold_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               tx_load, tx_bit, bit_end;
    logic               prefetch_done, pixel_end, last_pixel, latch_done, capture_now;
    logic [PIXEL_W-1:0] next_pixel;

    assign prefetch_done = (state_q == ST_PREFETCH) && (pre_cnt_q == LAT_LAST);
    assign pixel_end     = (state_q == ST_SEND) && bit_end && (bit_cnt_q == BIT_LAST);
    assign last_pixel    = (pix_cnt_q == PIX_LAST);
    assign latch_done    = (state_q == ST_LATCH) && (latch_cnt_q == LCH_LAST);
    assign capture_now   = fetch_busy_q && (fetch_cnt_q == LAT_LAST);
    // A capture landing on the very pixel boundary bypasses the hold register.
    assign next_pixel    = capture_now ? pixel_in : hold_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start_in)                 state_d = ST_PREFETCH;
            ST_PREFETCH: if (prefetch_done)            state_d = ST_SEND;
            ST_SEND:     if (pixel_end && last_pixel)  state_d = ST_LATCH;
            ST_LATCH:    if (latch_done)               state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pre_cnt_d    = pre_cnt_q;
        fetch_cnt_d  = fetch_cnt_q;
        fetch_busy_d = fetch_busy_q;
        bit_cnt_d    = bit_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        idx_d        = idx_q;
        latch_cnt_d  = latch_cnt_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        tx_load      = 1'b0;
        tx_bit       = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        done_d       = latch_done;

        if (fetch_busy_q) begin
            if (capture_now) begin
                hold_d       = pixel_in;
                fetch_busy_d = 1'b0;
            end else begin
                fetch_cnt_d = fetch_cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                pre_cnt_d = '0;
                idx_d     = '0;
            end
            ST_PREFETCH: begin
                pre_cnt_d = pre_cnt_q + 1'b1;
                if (prefetch_done) begin
                    pre_cnt_d = '0;
                    shift_d   = pixel_in;
                    tx_load   = 1'b1;
                    tx_bit    = pixel_in[PIXEL_W-1];
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                    if (LED_NUM > 1) begin
                        idx_d        = IDX_W'(1);
                        fetch_busy_d = 1'b1;
                        fetch_cnt_d  = '0;
                    end
                end
            end
            ST_SEND: begin
                if (bit_end) begin
                    if (bit_cnt_q != BIT_LAST) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        shift_d   = {shift_q[PIXEL_W-2:0], 1'b0};
                        tx_load   = 1'b1;
                        tx_bit    = shift_q[PIXEL_W-2];
                    end else if (last_pixel) begin
                        idx_d       = '0;
                        bit_cnt_d   = '0;
                        pix_cnt_d   = '0;
                        latch_cnt_d = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = next_pixel;
                        tx_load   = 1'b1;
                        tx_bit    = next_pixel[PIXEL_W-1];
                        // Fetch one pixel ahead of the one now starting.
                        if (int'(pix_cnt_q) + 2 < LED_NUM) begin
                            idx_d        = pix_cnt_q + IDX_W'(2);
                            fetch_busy_d = 1'b1;
                            fetch_cnt_d  = '0;
                        end
                    end
                end
            end
            ST_LATCH: begin
                latch_cnt_d = latch_done ? '0 : latch_cnt_q + 1'b1;
            end
            default: begin
                idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pre_cnt_q    <= '0;
            fetch_cnt_q  <= '0;
            fetch_busy_q <= 1'b0;
            bit_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            idx_q        <= '0;
            latch_cnt_q  <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            fetch_cnt_q  <= fetch_cnt_d;
            fetch_busy_q <= fetch_busy_d;
            bit_cnt_q    <= bit_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            idx_q        <= idx_d;
            latch_cnt_q  <= latch_cnt_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    ws2812_bit_tx #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_tx (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     (tx_load),
        .bit_in      (tx_bit),
        .dout_out    (dout_out),
        .bit_end_out (bit_end)
    );

    assign idx_out  = idx_q;
    assign busy_out = busy_q;
    assign done_out = done_q;

endmodule

// File: tb/tb_ws2812_frame_scan.sv
// Bench for ws2812_frame_scan: three configurations share one framebuffer
// model; each frame's line waveform is predicted from the pixel contents.
module tb_ws2812_frame_scan;
    import ws2812_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    int          sel;
    logic [23:0] mem [0:63];
    int          checks = 0;
    int          errors = 0;

    int cfg_n, cfg_lat, cfg_t0h, cfg_t1h, cfg_tbit, cfg_trst;

    logic        start_a, start_b, start_c;
    logic [0:0]  idx_a, addr_a;
    logic [3:0]  idx_b, addr_b1, addr_b2;
    logic [1:0]  idx_c, addr_c;
    logic [23:0] pix_a, pix_b, pix_c;
    logic        dout_a, busy_a, done_a;
    logic        dout_b, busy_b, done_b;
    logic        dout_c, busy_c, done_c;
    logic        m_dout, m_busy, m_done;
    int          m_idx;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    ws2812_frame_scan #(.LED_NUM(2), .RD_LATENCY(2), .T0H(3), .T1H(6), .TBIT(10), .TRST(50)) dut_a (
        .clk_in(clk), .rst_in(rst), .start_in(start_a), .idx_out(idx_a), .pixel_in(pix_a),
        .dout_out(dout_a), .busy_out(busy_a), .done_out(done_a));

    ws2812_frame_scan #(.LED_NUM(16), .RD_LATENCY(3), .T0H(3), .T1H(6), .TBIT(10), .TRST(50)) dut_b (
        .clk_in(clk), .rst_in(rst), .start_in(start_b), .idx_out(idx_b), .pixel_in(pix_b),
        .dout_out(dout_b), .busy_out(busy_b), .done_out(done_b));

    ws2812_frame_scan #(.LED_NUM(3)) dut_c (
        .clk_in(clk), .rst_in(rst), .start_in(start_c), .idx_out(idx_c), .pixel_in(pix_c),
        .dout_out(dout_c), .busy_out(busy_c), .done_out(done_c));

    // Framebuffer read paths: address register plus RAM register (and one more for dut_b).
    always @(posedge clk) begin
        addr_a  <= idx_a;
        pix_a   <= mem[addr_a];
        addr_b1 <= idx_b;
        addr_b2 <= addr_b1;
        pix_b   <= mem[addr_b2];
        addr_c  <= idx_c;
        pix_c   <= mem[addr_c];
    end

    always_comb begin
        m_dout = 1'b0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_idx  = 0;
        case (sel)
            0: begin m_dout = dout_a; m_busy = busy_a; m_done = done_a; m_idx = int'(idx_a); end
            1: begin m_dout = dout_b; m_busy = busy_b; m_done = done_b; m_idx = int'(idx_b); end
            default: begin m_dout = dout_c; m_busy = busy_c; m_done = done_c; m_idx = int'(idx_c); end
        endcase
    end

    typedef struct {
        logic [23:0] p0;
        logic [23:0] p1;
        int          want_long;
        int          want_high;
    } vec_t;

    vec_t vecs [5];

    task automatic applyStimulus(input logic s, input logic r);
        start = s;
        rst   = r;
    endtask

    task automatic checkOutput(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic selectDut(input int s);
        sel = s;
        if (s == 2) begin
            cfg_n = 3; cfg_lat = DEF_RD_LATENCY; cfg_t0h = DEF_T0H; cfg_t1h = DEF_T1H;
            cfg_tbit = DEF_TBIT; cfg_trst = DEF_TRST;
        end else begin
            cfg_n = (s == 0) ? 2 : 16; cfg_lat = (s == 0) ? 2 : 3;
            cfg_t0h = 3; cfg_t1h = 6; cfg_tbit = 10; cfg_trst = 50;
        end
    endtask

    // Expected line level j cycles after the accepting edge.
    function automatic logic expDout(input int j, input int base);
        int off, b, inpix, field, pos, th;
        if (j < base || j >= base + cfg_n * 24 * cfg_tbit) return 1'b0;
        off   = j - base;
        b     = off / cfg_tbit;
        inpix = b % 24;
        field = inpix / 8;
        pos   = ((field == 0) ? G_LSB : (field == 1) ? R_LSB : B_LSB) + 7 - (inpix % 8);
        th    = mem[b / 24][pos] ? cfg_t1h : cfg_t0h;
        return (off % cfg_tbit) < th;
    endfunction

    // Expects start high ahead of the next edge with the DUT idle.
    task automatic runFrame(input bit hold, input bit poke_latch, output int long_cnt, output int high_sum);
        int base, jend, jdone, bad_dout, bad_busy, bad_done, first_bad, run, idx_diff;
        int idx_seq[$];
        int want_seq[$];
        base = cfg_lat + 1;
        jend = base + cfg_n * 24 * cfg_tbit;
        jdone = jend + cfg_trst;
        bad_dout = 0; bad_busy = 0; bad_done = 0; first_bad = -1; run = 0;
        long_cnt = 0; high_sum = 0;
        @(posedge clk);
        @(negedge clk);
        if (!hold) applyStimulus(1'b0, 1'b0);
        checkOutput("busy_after_accept", m_busy, 1);
        checkOutput("idx_after_accept", m_idx, 0);
        idx_seq.push_back(m_idx);
        for (int j = 0; j <= jdone; j++) begin
            if (j > 0) begin
                @(negedge clk);
                if (m_idx != idx_seq[$]) idx_seq.push_back(m_idx);
            end
            if (m_dout !== expDout(j, base)) begin
                bad_dout++;
                if (first_bad < 0) first_bad = j;
            end
            if (m_busy !== (j < jdone)) bad_busy++;
            if (m_done !== (j == jdone)) bad_done++;
            if (m_dout) begin
                run++;
                high_sum++;
            end else if (run > 0) begin
                if (run == cfg_t1h) long_cnt++;
                run = 0;
            end
            if (poke_latch && j == jend + 5) applyStimulus(1'b1, 1'b0);
            if (poke_latch && j == jdone - 2) applyStimulus(1'b0, 1'b0);
        end
        checkOutput("dout_wave_bad_cycles", bad_dout, 0);
        if (bad_dout != 0) $display("[TB] first dout deviation %0d cycles after accept", first_bad);
        checkOutput("busy_bad_cycles", bad_busy, 0);
        checkOutput("done_bad_cycles", bad_done, 0);
        for (int i = 0; i < cfg_n; i++) want_seq.push_back(i);
        if (cfg_n > 1) want_seq.push_back(0);
        checkOutput("idx_seq_len", idx_seq.size(), want_seq.size());
        idx_diff = 0;
        for (int i = 0; i < idx_seq.size() && i < want_seq.size(); i++)
            if (idx_seq[i] != want_seq[i]) idx_diff++;
        checkOutput("idx_seq_diff", idx_diff, 0);
    endtask

    task automatic randomFill(input bit unique_idx);
        for (int i = 0; i < 64; i++)
            mem[i] = unique_idx ? {8'(i), 16'($urandom)} : 24'($urandom);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lc, hs, target, seen;
        vecs[0] = '{24'hFF0000, 24'h000001, 9, 171};
        vecs[1] = '{24'h000000, 24'h000000, 0, 144};
        vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 48, 288};
        vecs[3] = '{24'hA5A5A5, 24'h5A5A5A, 24, 216};
        vecs[4] = '{24'h800000, 24'h000001, 2, 150};
        for (int i = 0; i < 64; i++) mem[i] = '0;
        selectDut(0);
        applyStimulus(1'b0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            selectDut(s);
            #1;
            checkOutput("reset_dout", m_dout, 0);
            checkOutput("reset_busy", m_busy, 0);
            checkOutput("reset_done", m_done, 0);
            checkOutput("reset_idx", m_idx, 0);
        end
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);

        selectDut(0);
        for (int v = 0; v < 5; v++) begin
            mem[0] = vecs[v].p0;
            mem[1] = vecs[v].p1;
            applyStimulus(1'b1, 1'b0);
            runFrame(1'b0, 1'b0, lc, hs);
            checkOutput("vec_long_pulses", lc, vecs[v].want_long);
            checkOutput("vec_high_clocks", hs, vecs[v].want_high);
        end

        randomFill(1'b0);
        applyStimulus(1'b1, 1'b0);
        runFrame(1'b1, 1'b0, lc, hs);
        randomFill(1'b0);
        runFrame(1'b0, 1'b0, lc, hs);
        @(negedge clk);
        checkOutput("no_extra_frame_busy", m_busy, 0);

        randomFill(1'b0);
        applyStimulus(1'b1, 1'b0);
        runFrame(1'b0, 1'b1, lc, hs);
        @(negedge clk);
        checkOutput("latch_start_ignored_busy", m_busy, 0);

        selectDut(1);
        for (int f = 0; f < 2; f++) begin
            randomFill(1'b1);
            applyStimulus(1'b1, 1'b0);
            runFrame(1'b0, 1'b0, lc, hs);
        end

        selectDut(2);
        for (int i = 0; i < 64; i++) mem[i] = 24'hA5A5A5;
        applyStimulus(1'b1, 1'b0);
        runFrame(1'b0, 1'b0, lc, hs);
        checkOutput("a5_long_pulses", lc, 36);
        checkOutput("a5_high_clocks", hs, 1908);

        selectDut(1);
        randomFill(1'b1);
        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        target = cfg_lat + 1 + (5 * 24 + 12) * cfg_tbit + 1;
        for (int j = 1; j <= target; j++) @(negedge clk);
        checkOutput("dout_high_before_rst", m_dout, 1);
        checkOutput("idx_before_rst", m_idx, 6);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("rst_mid_dout", m_dout, 0);
        checkOutput("rst_mid_busy", m_busy, 0);
        checkOutput("rst_mid_idx", m_idx, 0);
        checkOutput("rst_mid_done", m_done, 0);
        applyStimulus(1'b0, 1'b0);
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (m_done || m_busy) seen++;
        end
        checkOutput("no_done_after_rst", seen, 0);

        randomFill(1'b1);
        applyStimulus(1'b1, 1'b0);
        runFrame(1'b0, 1'b0, lc, hs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
